// File: rtl/multicycle_sequencer.sv
// Moore control sequencer for the 16-bit multicycle datapath: fetch, decode,
// execute and writeback, with run gating, a HALT park state and a retire counter.
module multicycle_sequencer #(
   parameter int         CNT_WIDTH   = 16,
   parameter logic [3:0] HALT_OPCODE = 4'd15
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 run,
   input  logic [3:0]           opcode,
   input  logic                 zero,
   output logic                 esc_ir,
   output logic                 esc_cp,
   output logic                 esc_cond_cp,
   output logic [3:0]           ula_op,
   output logic                 ula_a,
   output logic [1:0]           ula_b,
   output logic [1:0]           fonte_cp,
   output logic                 esc_reg,
   output logic [3:0]           state,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] instr_count
);

   localparam logic [3:0] FETCH   = 4'd0;
   localparam logic [3:0] LOAD_IR = 4'd1;
   localparam logic [3:0] DECODE  = 4'd2;
   localparam logic [3:0] EXEC_R  = 4'd3;
   localparam logic [3:0] EXEC_I  = 4'd4;
   localparam logic [3:0] WB      = 4'd5;
   localparam logic [3:0] BRANCH  = 4'd6;
   localparam logic [3:0] JUMP    = 4'd7;
   localparam logic [3:0] HALT    = 4'd8;

   logic [3:0]           stateReg;
   logic [3:0]           nextState;
   logic [3:0]           opReg;
   logic                 immFlag;
   logic                 retire;
   logic [CNT_WIDTH-1:0] countReg;

   // The conditional PC write is resolved by the datapath, so the sequencer never needs zero.
   logic unusedZero;
   assign unusedZero = zero;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      nextState = FETCH;
      case (stateReg)
         FETCH:   nextState = run ? LOAD_IR : FETCH;
         LOAD_IR: nextState = DECODE;
         DECODE: begin
            if (opcode == HALT_OPCODE)  nextState = HALT;
            else if (opcode <= 4'd5)    nextState = EXEC_R;
            else if (opcode <= 4'd10)   nextState = EXEC_I;
            else if (opcode == 4'd11)   nextState = BRANCH;
            else if (opcode == 4'd12)   nextState = JUMP;
            else                        nextState = FETCH;
         end
         EXEC_R:  nextState = WB;
         EXEC_I:  nextState = WB;
         WB:      nextState = FETCH;
         BRANCH:  nextState = FETCH;
         JUMP:    nextState = FETCH;
         HALT:    nextState = HALT;
         default: nextState = FETCH;
      endcase
   end

   // A NOP retires straight out of DECODE; every other class retires on its last state.
   assign retire = (stateReg == WB) || (stateReg == BRANCH) || (stateReg == JUMP) ||
                   ((stateReg == DECODE) && (nextState == FETCH));

   always_ff @(posedge CLOCK_50) begin
      // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch.
      if (!reset) begin
         stateReg <= FETCH;
         opReg    <= '0;
         immFlag  <= 1'b0;
         countReg <= '0;
      end else begin
         stateReg <= nextState;
         if (stateReg == DECODE) begin
            opReg   <= opcode;
            immFlag <= (opcode >= 4'd6) && (opcode <= 4'd10);
         end
         if (retire) countReg <= countReg + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      esc_ir      = 1'b0;
      esc_cp      = 1'b0;
      esc_cond_cp = 1'b0;
      ula_op      = 4'd0;
      ula_a       = 1'b0;
      ula_b       = 2'b00;
      fonte_cp    = 2'b00;
      esc_reg     = 1'b0;
      halted      = 1'b0;
      case (stateReg)
         LOAD_IR: begin
            esc_ir = 1'b1;
            esc_cp = 1'b1;
            ula_a  = 1'b1;
            ula_b  = 2'b01;
         end
         EXEC_R: ula_op = opReg;
         EXEC_I: begin
            ula_op = opReg;
            ula_b  = 2'b10;
         end
         WB: begin
            ula_op  = opReg;
            ula_b   = immFlag ? 2'b10 : 2'b00;
            esc_reg = 1'b1;
         end
         BRANCH: begin
            ula_op      = 4'd1;
            esc_cond_cp = 1'b1;
            fonte_cp    = 2'b01;
         end
         JUMP: begin
            esc_cp   = 1'b1;
            fonte_cp = 2'b10;
         end
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

   assign state       = stateReg;
   assign instr_count = countReg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: table of per-cycle vectors plus
// hand-written halt, mid-instruction reset and counter-wrap sequences.
module tb_multicycle_sequencer;

   logic        CLOCK_50;
   logic        reset, run, zero;
   logic [3:0]  opcode;
   logic        esc_ir, esc_cp, esc_cond_cp, ula_a, esc_reg, halted;
   logic [3:0]  ula_op, state;
   logic [1:0]  ula_b, fonte_cp;
   logic [15:0] instr_count;

   // Narrow-counter instance used only to exercise wrap-around in a short run.
   logic        resetB, runB;
   logic [3:0]  opcodeB;
   logic        irB, cpB, condB, aB, regB, haltB;
   logic [3:0]  opB, stateB;
   logic [1:0]  bB, fcB;
   logic [3:0]  countB;

   int passCount  = 0;
   int checkCount = 0;
   int mutexErr   = 0;

   multicycle_sequencer #(.CNT_WIDTH(16), .HALT_OPCODE(4'd15)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
      .esc_ir(esc_ir), .esc_cp(esc_cp), .esc_cond_cp(esc_cond_cp), .ula_op(ula_op),
      .ula_a(ula_a), .ula_b(ula_b), .fonte_cp(fonte_cp), .esc_reg(esc_reg),
      .state(state), .halted(halted), .instr_count(instr_count)
   );

   multicycle_sequencer #(.CNT_WIDTH(4), .HALT_OPCODE(4'd15)) dutWrap (
      .CLOCK_50(CLOCK_50), .reset(resetB), .run(runB), .opcode(opcodeB), .zero(1'b0),
      .esc_ir(irB), .esc_cp(cpB), .esc_cond_cp(condB), .ula_op(opB),
      .ula_a(aB), .ula_b(bB), .fonte_cp(fcB), .esc_reg(regB),
      .state(stateB), .halted(haltB), .instr_count(countB)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) if (esc_cp && esc_cond_cp) mutexErr++;

   logic [17:0] actOut;
   assign actOut = {state, halted, esc_ir, esc_cp, esc_cond_cp, ula_op, ula_a, ula_b, fonte_cp, esc_reg};

   typedef struct {
      logic        rst;
      logic        run;
      logic [3:0]  op;
      logic        zero;
      logic [17:0] expOut;
      logic [15:0] expCnt;
   } vecT;

   vecT vecs[$];

   function automatic logic [17:0] mk(input logic [3:0] st, input logic hlt, input logic ir,
                                      input logic cp, input logic cond, input logic [3:0] op,
                                      input logic a, input logic [1:0] b, input logic [1:0] fc,
                                      input logic rg);
      return {st, hlt, ir, cp, cond, op, a, b, fc, rg};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic addVec(input logic rn, input logic [3:0] op, input logic z,
                         input logic [17:0] eo, input logic [15:0] ec);
      vecT v;
      v.rst = 1'b1; v.run = rn; v.op = op; v.zero = z; v.expOut = eo; v.expCnt = ec;
      vecs.push_back(v);
   endtask

   logic [17:0] oFetch, oLoad, oDec, oHalt;

   initial begin
      oFetch = mk(4'd0, 0, 0, 0, 0, 4'd0, 0, 2'b00, 2'b00, 0);
      oLoad  = mk(4'd1, 0, 1, 1, 0, 4'd0, 1, 2'b01, 2'b00, 0);
      oDec   = mk(4'd2, 0, 0, 0, 0, 4'd0, 0, 2'b00, 2'b00, 0);
      oHalt  = mk(4'd8, 1, 0, 0, 0, 4'd0, 0, 2'b00, 2'b00, 0);

      // R-type add-class, opcode 2
      addVec(1, 4'd2, 0, oLoad, 16'd0);
      addVec(1, 4'd2, 0, oDec, 16'd0);
      addVec(1, 4'd2, 0, mk(4'd3, 0, 0, 0, 0, 4'd2, 0, 2'b00, 2'b00, 0), 16'd0);
      addVec(1, 4'd2, 0, mk(4'd5, 0, 0, 0, 0, 4'd2, 0, 2'b00, 2'b00, 1), 16'd0);
      addVec(1, 4'd2, 0, oFetch, 16'd1);
      // I-type, opcode 7
      addVec(1, 4'd7, 0, oLoad, 16'd1);
      addVec(1, 4'd7, 0, oDec, 16'd1);
      addVec(1, 4'd7, 0, mk(4'd4, 0, 0, 0, 0, 4'd7, 0, 2'b10, 2'b00, 0), 16'd1);
      addVec(1, 4'd7, 0, mk(4'd5, 0, 0, 0, 0, 4'd7, 0, 2'b10, 2'b00, 1), 16'd1);
      addVec(1, 4'd7, 0, oFetch, 16'd2);
      // BEQ, opcode 11, zero=1
      addVec(1, 4'd11, 1, oLoad, 16'd2);
      addVec(1, 4'd11, 1, oDec, 16'd2);
      addVec(1, 4'd11, 1, mk(4'd6, 0, 0, 0, 1, 4'd1, 0, 2'b00, 2'b01, 0), 16'd2);
      addVec(1, 4'd11, 1, oFetch, 16'd3);
      // JMP, opcode 12
      addVec(1, 4'd12, 0, oLoad, 16'd3);
      addVec(1, 4'd12, 0, oDec, 16'd3);
      addVec(1, 4'd12, 0, mk(4'd7, 0, 0, 1, 0, 4'd0, 0, 2'b00, 2'b10, 0), 16'd3);
      addVec(1, 4'd12, 0, oFetch, 16'd4);
      // NOP, opcode 13, then a stall with run low
      addVec(1, 4'd13, 0, oLoad, 16'd4);
      addVec(1, 4'd13, 0, oDec, 16'd4);
      addVec(1, 4'd13, 0, oFetch, 16'd5);
      addVec(0, 4'd13, 0, oFetch, 16'd5);
      // opcode 3 latched in DECODE, then opcode changes to 9 during EXEC/WB
      addVec(1, 4'd3, 0, oLoad, 16'd5);
      addVec(1, 4'd3, 0, oDec, 16'd5);
      addVec(1, 4'd3, 0, mk(4'd3, 0, 0, 0, 0, 4'd3, 0, 2'b00, 2'b00, 0), 16'd5);
      addVec(1, 4'd9, 0, mk(4'd5, 0, 0, 0, 0, 4'd3, 0, 2'b00, 2'b00, 1), 16'd5);
      addVec(1, 4'd9, 0, oFetch, 16'd6);
      // HALT, opcode 15
      addVec(1, 4'd15, 0, oLoad, 16'd6);
      addVec(1, 4'd15, 0, oDec, 16'd6);
      addVec(1, 4'd15, 0, oHalt, 16'd6);

      reset = 1'b0; run = 1'b0; opcode = 4'd0; zero = 1'b0;
      resetB = 1'b0; runB = 1'b0; opcodeB = 4'd0;
      step();
      check("reset_out", {14'd0, actOut}, {14'd0, oFetch});
      check("reset_cnt", {16'd0, instr_count}, 32'd0);

      reset = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("idle_out", {14'd0, actOut}, {14'd0, oFetch});
      check("idle_cnt", {16'd0, instr_count}, 32'd0);

      foreach (vecs[i]) begin
         reset = vecs[i].rst; run = vecs[i].run; opcode = vecs[i].op; zero = vecs[i].zero;
         step();
         check($sformatf("vec%0d_out", i), {14'd0, actOut}, {14'd0, vecs[i].expOut});
         check($sformatf("vec%0d_cnt", i), {16'd0, instr_count}, {16'd0, vecs[i].expCnt});
      end

      // HALT holds regardless of run
      for (int i = 0; i < 20; i++) begin
         run = i[0];
         opcode = 4'd0;
         step();
         check($sformatf("halt%0d_out", i), {14'd0, actOut}, {14'd0, oHalt});
      end
      check("halt_cnt", {16'd0, instr_count}, 32'd6);

      reset = 1'b0;
      step();
      check("unhalt_out", {14'd0, actOut}, {14'd0, oFetch});
      check("unhalt_cnt", {16'd0, instr_count}, 32'd0);

      // reset while in EXEC_R must abort without a register write
      reset = 1'b1; run = 1'b1; opcode = 4'd0;
      step();
      check("abort_load", {14'd0, actOut}, {14'd0, oLoad});
      step();
      check("abort_dec", {14'd0, actOut}, {14'd0, oDec});
      step();
      check("abort_exec", {14'd0, actOut}, {14'd0, mk(4'd3, 0, 0, 0, 0, 4'd0, 0, 2'b00, 2'b00, 0)});
      reset = 1'b0;
      step();
      check("abort_rst", {14'd0, actOut}, {14'd0, oFetch});
      reset = 1'b1; run = 1'b0;
      step();
      check("abort_after", {14'd0, actOut}, {14'd0, oFetch});
      check("abort_cnt", {16'd0, instr_count}, 32'd0);

      // counter wrap on the 4-bit instance: 15 NOPs reach max, the 16th wraps
      resetB = 1'b1; runB = 1'b1; opcodeB = 4'd13;
      for (int i = 0; i < 45; i++) step();
      check("wrap_max", {28'd0, countB}, 32'd15);
      step();
      step();
      check("wrap_hold", {28'd0, countB}, 32'd15);
      step();
      check("wrap_zero", {28'd0, countB}, 32'd0);
      check("wrap_state", {28'd0, stateB}, 32'd0);

      check("mutex", mutexErr, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
